// File: rtl/buzzer_pkg.sv
// Shared types, field widths and note lookup
// for the buzzer melody sequencer.
package buzzer_pkg;

  localparam int unsigned NOTE_W  = 5;
  localparam int unsigned DUR_W   = 8;
  localparam int unsigned ENTRY_W = NOTE_W + DUR_W;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 5'd1;
  localparam logic [NOTE_W-1:0] NOTE_A4   = 5'd10;
  localparam logic [NOTE_W-1:0] NOTE_C5   = 5'd13;
  localparam logic [NOTE_W-1:0] NOTE_B5   = 5'd24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_e;

  // Equal-temperament frequency in Hz, C4..B5.
  // Unused codes are rests.
  function automatic logic [31:0] note_hz(
    input logic [NOTE_W-1:0] code
  );
    logic [31:0] hz;
    hz = 32'd0;
    case (code)
      NOTE_REST: hz = 32'd0;
      NOTE_C4:   hz = 32'd262;
      5'd2:      hz = 32'd277;
      5'd3:      hz = 32'd294;
      5'd4:      hz = 32'd311;
      5'd5:      hz = 32'd330;
      5'd6:      hz = 32'd349;
      5'd7:      hz = 32'd370;
      5'd8:      hz = 32'd392;
      5'd9:      hz = 32'd415;
      NOTE_A4:   hz = 32'd440;
      5'd11:     hz = 32'd466;
      5'd12:     hz = 32'd494;
      NOTE_C5:   hz = 32'd523;
      5'd14:     hz = 32'd554;
      5'd15:     hz = 32'd587;
      5'd16:     hz = 32'd622;
      5'd17:     hz = 32'd659;
      5'd18:     hz = 32'd698;
      5'd19:     hz = 32'd740;
      5'd20:     hz = 32'd784;
      5'd21:     hz = 32'd831;
      5'd22:     hz = 32'd880;
      5'd23:     hz = 32'd932;
      NOTE_B5:   hz = 32'd988;
      default:   hz = 32'd0;
    endcase
    return hz;
  endfunction

endpackage

// File: rtl/buzzer_tick_gen.sv
// Unit-tick prescaler: one-clock o_tick every
// LIMIT+1 clocks, restarted by a synchronous clear.
module buzzer_tick_gen #(
  parameter logic [31:0] LIMIT = 32'd0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  output logic o_tick
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Count up to LIMIT, pulse, and wrap to zero.
  always_comb begin
    cnt_d  = cnt_q + 32'd1;
    o_tick = 1'b0;
    if (i_clr) begin
      cnt_d = '0;
    end else if (cnt_q == LIMIT) begin
      cnt_d  = '0;
      o_tick = 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/buzzer_melody_seq.sv
// Melody sequencer: steps a writable
// {note,dur} table and drives o_freq in Hz.
import buzzer_pkg::*;

module buzzer_melody_seq #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned UNIT_MS    = 10,
  parameter int unsigned MELODY_LEN = 16,
  parameter int unsigned GAP_UNITS  = 2,
  localparam int unsigned AW = $clog2(MELODY_LEN)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_loop,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [ENTRY_W-1:0] i_wr_data,
  output logic [31:0]        o_freq,
  output logic               o_busy,
  output logic               o_done,
  output logic [AW-1:0]      o_note_idx
);

  localparam logic [31:0] TICK_LIMIT =
    32'(CLK_HZ / 1000 * UNIT_MS - 1);
  localparam logic [DUR_W-1:0] GAP_CNT =
    DUR_W'(GAP_UNITS);
  localparam logic [AW-1:0] LAST_IDX =
    AW'(MELODY_LEN - 1);

  logic [ENTRY_W-1:0] tab_q [MELODY_LEN];
  logic [ENTRY_W-1:0] tab_d [MELODY_LEN];

  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        freq_q, freq_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;

  logic               tick;
  logic               tick_clr;
  logic [ENTRY_W-1:0] ent;
  logic [NOTE_W-1:0]  ent_note;
  logic [DUR_W-1:0]   ent_dur;

  assign ent      = tab_q[idx_q];
  assign ent_note = ent[ENTRY_W-1:DUR_W];
  assign ent_dur  = ent[DUR_W-1:0];

  // Prescaler only runs while a note or gap is timed;
  // it restarts on every LOAD so each note is exact.
  assign tick_clr = (state_q != ST_PLAY) &&
                    (state_q != ST_GAP);

  buzzer_tick_gen #(
    .LIMIT (TICK_LIMIT)
  ) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (tick_clr),
    .o_tick  (tick)
  );

  // Table write port; usable in any state.
  always_comb begin
    tab_d = tab_q;
    if (i_wr_en) tab_d[i_wr_addr] = i_wr_data;
  end

  // Table storage, cleared by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(MELODY_LEN); i++)
        tab_q[i] <= '0;
    end else begin
      tab_q <= tab_d;
    end
  end

  // Next-state and output logic; stop overrides all.
  // wrap_q marks a LOAD reached by running off the
  // end of the table, handled like an end marker.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    freq_d  = freq_q;
    done_d  = 1'b0;
    wrap_d  = wrap_q;
    if (i_stop) begin
      state_d = ST_IDLE;
      freq_d  = '0;
      wrap_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          freq_d = '0;
          if (i_start) begin
            state_d = ST_LOAD;
            idx_d   = '0;
            wrap_d  = 1'b0;
          end
        end
        ST_LOAD: begin
          if (ent_dur != '0 && !wrap_q) begin
            state_d = ST_PLAY;
            freq_d  = note_hz(ent_note);
            cnt_d   = ent_dur;
          end else if (idx_q == '0 && !wrap_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (i_loop) begin
            idx_d  = '0;
            wrap_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
            freq_d  = '0;
            done_d  = 1'b1;
            wrap_d  = 1'b0;
          end
        end
        ST_PLAY: begin
          if (tick) begin
            if (cnt_q == DUR_W'(1)) begin
              freq_d = '0;
              if (GAP_UNITS != 0) begin
                state_d = ST_GAP;
                cnt_d   = GAP_CNT;
              end else begin
                state_d = ST_LOAD;
                idx_d   = idx_q + AW'(1);
                wrap_d  = (idx_q == LAST_IDX);
              end
            end else begin
              cnt_d = cnt_q - DUR_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (cnt_q == DUR_W'(1)) begin
              state_d = ST_LOAD;
              idx_d   = idx_q + AW'(1);
              wrap_d  = (idx_q == LAST_IDX);
            end else begin
              cnt_d = cnt_q - DUR_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      freq_q  <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_freq     = freq_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;
  assign o_note_idx = idx_q;

endmodule

// File: tb/tb_buzzer_melody_seq.sv
// Bench: two sequencers (legato / gapped+prescaled)
// against a trace-expanding melody model.
module tb_buzzer_melody_seq;

  localparam int NM  = 2;
  localparam int LEN = 16;

  typedef struct packed {
    logic [31:0] f;
    logic        b;
    logic        d;
    logic [3:0]  i;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [12:0] wr_data = '0;

  logic [31:0] freq_a, freq_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic [3:0]  idx_a, idx_b;

  always #5 clk = ~clk;

  buzzer_melody_seq #(
    .CLK_HZ(1000), .UNIT_MS(1),
    .MELODY_LEN(16), .GAP_UNITS(0)
  ) dut_a (
    .i_clk(clk), .i_reset(rst),
    .i_start(start), .i_stop(stop),
    .i_loop(loop), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_freq(freq_a), .o_busy(busy_a),
    .o_done(done_a), .o_note_idx(idx_a)
  );

  buzzer_melody_seq #(
    .CLK_HZ(2000), .UNIT_MS(1),
    .MELODY_LEN(16), .GAP_UNITS(2)
  ) dut_b (
    .i_clk(clk), .i_reset(rst),
    .i_start(start), .i_stop(stop),
    .i_loop(loop), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_freq(freq_b), .o_busy(busy_b),
    .o_done(done_b), .o_note_idx(idx_b)
  );

  // Model: clocks per unit and gap units per DUT.
  int          tck [NM] = '{1, 2};
  int          gapu[NM] = '{0, 2};
  logic [12:0] mtab[LEN];
  exp_t        mq  [NM][$];
  exp_t        cur [NM];
  bit          playing[NM];
  int          ptr [NM];

  int n_cmp = 0;
  int n_bad = 0;
  int cb[NM], cd[NM], c440[NM], c523[NM], cnz[NM];

  function automatic int hz(int code);
    real r;
    if (code < 1 || code > 24) return 0;
    r = 440.0 * (2.0 ** (real'(code - 10) / 12.0));
    return $rtoi(r + 0.5);
  endfunction

  function automatic exp_t got(int m);
    if (m == 0) return {freq_a, busy_a, done_a, idx_a};
    return {freq_b, busy_b, done_b, idx_b};
  endfunction

  task automatic lit(string nm, int g, int w);
    n_cmp++;
    if (g != w) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, g, w);
    end
  endtask

  // Expand one table step into the per-cycle trace:
  // a LOAD clock, the note, then any gap.
  task automatic expand(int m);
    logic [12:0] e;
    exp_t x;
    int p;
    p = ptr[m];
    e = (p < LEN) ? mtab[p] : 13'd0;
    x.f = '0; x.b = 1'b1; x.d = 1'b0;
    x.i = 4'(p % LEN);
    mq[m].push_back(x);
    if (e[7:0] != 0) begin
      x.f = 32'(hz(int'(e[12:8])));
      repeat (int'(e[7:0]) * tck[m]) mq[m].push_back(x);
      x.f = '0;
      repeat (gapu[m] * tck[m]) mq[m].push_back(x);
      ptr[m] = p + 1;
    end else if (p != 0 && loop) begin
      ptr[m] = 0;
    end else begin
      x.b = 1'b0; x.d = 1'b1;
      mq[m].push_back(x);
      playing[m] = 1'b0;
    end
  endtask

  task automatic model_next(int m);
    exp_t idle;
    idle = '0;
    idle.i = cur[m].i;
    if (stop) begin
      mq[m].delete();
      playing[m] = 1'b0;
      cur[m] = idle;
    end else begin
      if (mq[m].size() == 0) begin
        if (playing[m]) begin
          expand(m);
        end else if (start) begin
          playing[m] = 1'b1;
          ptr[m] = 0;
          expand(m);
        end
      end
      if (mq[m].size() != 0) cur[m] = mq[m].pop_front();
      else                   cur[m] = idle;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LEN; i++) mtab[i] = '0;
    for (int m = 0; m < NM; m++) begin
      mq[m].delete();
      playing[m] = 1'b0;
      cur[m] = '0;
    end
  endtask

  task automatic clr_cnt();
    for (int m = 0; m < NM; m++) begin
      cb[m] = 0; cd[m] = 0; c440[m] = 0;
      c523[m] = 0; cnz[m] = 0;
    end
  endtask

  // Per-cycle compare of every output on both DUTs.
  task automatic check_all();
    exp_t g;
    for (int m = 0; m < NM; m++) begin
      g = got(m);
      n_cmp++;
      if (g !== cur[m]) begin
        n_bad++;
        $display("FAIL cyc dut%0d t=%0t: got f=%0d b=%0d d=%0d i=%0d want f=%0d b=%0d d=%0d i=%0d",
          m, $time, g.f, g.b, g.d, g.i,
          cur[m].f, cur[m].b, cur[m].d, cur[m].i);
      end
      cb[m]   += int'(g.b);
      cd[m]   += int'(g.d);
      c440[m] += (g.f == 32'd440) ? 1 : 0;
      c523[m] += (g.f == 32'd523) ? 1 : 0;
      cnz[m]  += (g.f != 0) ? 1 : 0;
    end
  endtask

  task automatic cyc();
    if (wr_en) mtab[wr_addr] = wr_data;
    for (int m = 0; m < NM; m++) model_next(m);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic wr(int a, int note, int dur);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_data = {5'(note), 8'(dur)};
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    lit("rst freq_a", int'(freq_a), 0);
    lit("rst busy_a", int'(busy_a), 0);
    lit("rst done_b", int'(done_b), 0);
    lit("rst freq_b", int'(freq_b), 0);
    lit("rst idx_b",  int'(idx_b),  0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic song();
    wr(0, 10, 3);
    wr(1, 13, 2);
    wr(2, 0, 0);
  endtask

  initial begin
    model_reset();
    clr_cnt();
    do_reset();

    lit("hz C4", hz(1), 262);
    lit("hz A4", hz(10), 440);
    lit("hz C5", hz(13), 523);
    lit("hz B5", hz(24), 988);

    // Single play; rewrite of the sounding entry.
    song();
    loop = 1'b0;
    clr_cnt();
    pulse_start();
    run(2);
    wr(0, 24, 9);
    wr(0, 10, 3);
    run(30);
    lit("t1 busyA", cb[0], 8);
    lit("t1 doneA", cd[0], 1);
    lit("t1 440A", c440[0], 3);
    lit("t1 523A", c523[0], 2);
    lit("t2 busyB", cb[1], 21);
    lit("t2 doneB", cd[1], 1);
    lit("t2 440B", c440[1], 6);
    lit("t2 523B", c523[1], 4);

    // Looping playback, then stop.
    loop = 1'b1;
    clr_cnt();
    pulse_start();
    run(19);
    lit("t3 440A", c440[0], 9);
    lit("t3 doneA", cd[0], 0);
    lit("t3 doneB", cd[1], 0);
    stop = 1'b1; cyc(); stop = 1'b0;
    lit("t3 stop fA", int'(freq_a), 0);
    lit("t3 stop bB", int'(busy_b), 0);
    lit("t3 stop dA", int'(done_a), 0);
    loop = 1'b0;
    run(2);

    // Empty table.
    wr(0, 0, 0);
    clr_cnt();
    pulse_start();
    run(4);
    lit("t4 busyA", cb[0], 1);
    lit("t4 doneA", cd[0], 1);
    lit("t4 busyB", cb[1], 1);
    lit("t4 freqB", cnz[1], 0);

    // Start+stop together; start while busy.
    wr(0, 10, 3);
    clr_cnt();
    start = 1'b1; stop = 1'b1; cyc();
    start = 1'b0; stop = 1'b0;
    run(3);
    lit("t5 busyA", cb[0], 0);
    pulse_start();
    run(2);
    pulse_start();
    run(30);

    // Full table wraps to done.
    for (int i = 0; i < LEN; i++)
      wr(i, 1 + (i % 24), 1 + (i % 3));
    clr_cnt();
    pulse_start();
    run(200);
    lit("t6 wrap doneA", cd[0], 1);
    lit("t6 wrap doneB", cd[1], 1);

    // Reset mid-note; table comes back empty.
    pulse_start();
    run(3);
    lit("t6 playing A", (freq_a != 0) ? 1 : 0, 1);
    do_reset();
    clr_cnt();
    pulse_start();
    run(4);
    lit("t6 clr busyA", cb[0], 1);
    lit("t6 clr doneB", cd[1], 1);

    // Randomized runs.
    for (int r = 0; r < 40; r++) begin
      stop = 1'b1; cyc(); stop = 1'b0;
      loop = 1'($urandom_range(0, 1));
      for (int i = 0; i < LEN; i++) begin
        int d;
        d = ($urandom_range(0, 5) == 0) ?
            0 : int'($urandom_range(1, 4));
        if ($urandom_range(0, 2) == 0)
          wr(i, int'($urandom_range(0, 31)), d);
      end
      pulse_start();
      for (int c = 0; c < int'($urandom_range(10, 150));
           c++) begin
        stop  = ($urandom_range(0, 79) == 0);
        start = ($urandom_range(0, 9) == 0);
        cyc();
      end
      stop = 1'b0;
      start = 1'b0;
    end
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
